// File: rtl/riscv_pkg.sv
// Shared constants and small types for the integer register file and its
// pending-write scoreboard.
//   XLEN       : data width of one architectural register
//   REG_IDX_W  : register index width (5 -> 32 registers)
//   NUM_REGS   : number of architectural registers
//   CNT_W      : width of one pending-write counter
//   REG_ZERO   : x0, hard-wired zero
//   REG_RA     : x1, return-address register mirrored on x1_value
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;
  localparam int CNT_W     = 2;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd1;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter of the scoreboard: saturating up/down counter.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   inc, dec   : issue / retire event for this register this cycle
//   cnt        : current pending count
//   busy       : registered (next count != 0)
//   ovf        : pulse, an increment hit the saturated maximum this cycle
//   unf        : pulse, a decrement found the counter already at zero
module sb_counter
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             ovf,
  output logic             unf
);

  logic [CNT_W-1:0] cnt_next;

  // Simultaneous issue and retire cancel out and never raise a flag.
  always_comb begin
    cnt_next = cnt;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (inc && !dec) begin
      if (cnt == '1) ovf      = 1'b1;
      else           cnt_next = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) unf      = 1'b1;
      else           cnt_next = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural integer register file (32 x XLEN) with a per-register
// pending-write scoreboard that raises an ID-stage RAW stall.
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   defined   : write-first reads and stall release in the retire cycle
//   undefined : reads see stored values only, stall releases after retire
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   wb_regwrite, wb_rd, wb_write_data   : write-back port (also retires a write)
//   id_rs1, id_rs2, id_rs1_used/_used   : ID source operands
//   id_issue, id_issue_we, id_issue_rd  : instruction leaving ID, its rd
//   rs1_data, rs2_data                  : combinational read data
//   id_stall                            : combinational RAW hazard
//   busy_mask                           : registered per-register pending flag
//   x1_value                            : registered mirror of x1
//   sb_overflow, sb_underflow           : sticky scoreboard error flags
module regfile_scoreboard
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_regwrite,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_write_data,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 id_issue,
  input  logic                 id_issue_we,
  input  logic [REG_IDX_W-1:0] id_issue_rd,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 id_stall,
  output logic [NUM_REGS-1:0]  busy_mask,
  output logic [XLEN-1:0]      x1_value,
  output logic                 sb_overflow,
  output logic                 sb_underflow
);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic                wb_we;
  logic                issue_we;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] ovf;
  logic [NUM_REGS-1:0] unf;
  logic [NUM_REGS-1:0] eff_busy;

  assign wb_we    = wb_regwrite && (wb_rd != REG_ZERO);
  assign issue_we = id_issue && id_issue_we && (id_issue_rd != REG_ZERO);

  // x0 has no counter: it is never pending and never stalls.
  assign inc[0]       = 1'b0;
  assign dec[0]       = 1'b0;
  assign ovf[0]       = 1'b0;
  assign unf[0]       = 1'b0;
  assign eff_busy[0]  = 1'b0;
  assign busy_mask[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
    cnt_t cnt;

    assign inc[gi] = issue_we && (id_issue_rd == REG_IDX_W'(gi));
    assign dec[gi] = wb_we && (wb_rd == REG_IDX_W'(gi));

    sb_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[gi]),
      .dec   (dec[gi]),
      .cnt   (cnt),
      .busy  (busy_mask[gi]),
      .ovf   (ovf[gi]),
      .unf   (unf[gi])
    );

`ifdef REGFILE_WB_BYPASS_EN
    // cnt - dec, clamped at zero: a retire into an idle counter is an
    // underflow error, not a pending write, so it must not stall.
    assign eff_busy[gi] = (cnt != '0) && !(dec[gi] && (cnt == cnt_t'(1)));
`else
    assign eff_busy[gi] = (cnt != '0);
`endif
  end

  always_comb begin
    rs1_data = '0;
    if (id_rs1 != REG_ZERO) begin
      rs1_data = regs[id_rs1];
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_regwrite && (wb_rd == id_rs1)) rs1_data = wb_write_data;
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (id_rs2 != REG_ZERO) begin
      rs2_data = regs[id_rs2];
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_regwrite && (wb_rd == id_rs2)) rs2_data = wb_write_data;
`endif
    end
  end

  assign id_stall = (id_rs1_used && eff_busy[id_rs1]) ||
                    (id_rs2_used && eff_busy[id_rs2]);

  // regs[0] is cleared on reset and never written, so x0 reads as zero
  // even before the read mux forces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      x1_value <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_write_data;
      if (wb_rd == REG_RA) x1_value <= wb_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_overflow  <= 1'b0;
      sb_underflow <= 1'b0;
    end else begin
      sb_overflow  <= sb_overflow  | (|ovf);
      sb_underflow <= sb_underflow | (|unf);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        id_issue;
  logic        id_issue_we;
  logic [4:0]  id_issue_rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        id_stall;
  logic [31:0] busy_mask;
  logic [31:0] x1_value;
  logic        sb_overflow;
  logic        sb_underflow;

  regfile_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .wb_regwrite   (wb_regwrite),
    .wb_rd         (wb_rd),
    .wb_write_data (wb_write_data),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_issue      (id_issue),
    .id_issue_we   (id_issue_we),
    .id_issue_rd   (id_issue_rd),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .id_stall      (id_stall),
    .busy_mask     (busy_mask),
    .x1_value      (x1_value),
    .sb_overflow   (sb_overflow),
    .sb_underflow  (sb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending-write count and stored value per register.
  int          mcnt  [32];
  logic [31:0] mregs [32];
  bit          movf;
  bit          munf;

  typedef struct {
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wdata;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        iss;
    logic        iwe;
    logic [4:0]  ird;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wbw, logic [4:0] wbrd, logic [31:0] wdata,
                              logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic iss, logic iwe, logic [4:0] ird,
                              logic [31:0] e1, logic [31:0] e2, logic es);
    vec_t v;
    v.wbw = wbw; v.wbrd = wbrd; v.wdata = wdata;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.iss = iss; v.iwe = iwe; v.ird = ird;
    v.e_rs1 = e1; v.e_rs2 = e2; v.e_stall = es;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mcnt[r]  = 0;
      mregs[r] = 32'h0;
    end
    movf = 1'b0;
    munf = 1'b0;
  endtask

  task automatic idle_inputs();
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_write_data = 32'h0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_issue = 1'b0; id_issue_we = 1'b0; id_issue_rd = 5'd0;
  endtask

  function automatic logic [31:0] exp_read(logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (BYP && wb_regwrite && wb_rd == rs) return wb_write_data;
    return mregs[rs];
  endfunction

  function automatic bit exp_pending(logic [4:0] r);
    int e;
    if (r == 5'd0) return 1'b0;
    e = mcnt[r];
    if (BYP && wb_regwrite && wb_rd == r) e = e - 1;
    return e > 0;
  endfunction

  task automatic check_comb(string tag);
    #1;
    check({tag, " rs1_data"}, rs1_data, exp_read(id_rs1));
    check({tag, " rs2_data"}, rs2_data, exp_read(id_rs2));
    check({tag, " id_stall"}, id_stall,
          (id_rs1_used && exp_pending(id_rs1)) || (id_rs2_used && exp_pending(id_rs2)));
  endtask

  // Advance one rising edge, apply the event rules to the model, then
  // compare every registered output.
  task automatic tick(string tag);
    bit          wbw, isw;
    logic [4:0]  wr, ir;
    logic [31:0] wd;
    logic [31:0] em;
    wbw = wb_regwrite && wb_rd != 5'd0;
    isw = id_issue && id_issue_we && id_issue_rd != 5'd0;
    wr  = wb_rd;
    ir  = id_issue_rd;
    wd  = wb_write_data;
    @(posedge clk);
    #1;
    if (isw && !(wbw && wr == ir)) begin
      if (mcnt[ir] == 3) movf = 1'b1;
      else mcnt[ir] = mcnt[ir] + 1;
    end
    if (wbw && !(isw && wr == ir)) begin
      if (mcnt[wr] == 0) munf = 1'b1;
      else mcnt[wr] = mcnt[wr] - 1;
    end
    if (wbw) mregs[wr] = wd;
    em = 32'h0;
    for (int r = 1; r < 32; r++) em[r] = (mcnt[r] != 0);
    check({tag, " busy_mask"}, busy_mask, em);
    check({tag, " x1_value"}, x1_value, mregs[1]);
    check({tag, " sb_overflow"}, sb_overflow, movf);
    check({tag, " sb_underflow"}, sb_underflow, munf);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;

    // Directed vectors; expected read/stall values worked out by hand.
    tbl.push_back(mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h00001234, 5, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 7, 32'h55, 7, 1, 0, 0, 0, 0, 0, BYP ? 32'h55 : 32'h0, 0, BYP ? 1'b0 : 1'b1));
    tbl.push_back(mk(0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 32'h55, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0));
    tbl.push_back(mk(1, 9, 32'h99, 0, 0, 9, 1, 1, 1, 9, 0, BYP ? 32'h99 : 32'h0, BYP ? 1'b0 : 1'b1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 32'h99, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 11, 1, 0, 0, 1, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 1, 0, 0, 1, 1, 3, 0, 0, 1));
    tbl.push_back(mk(1, 1, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 32'h0000CAFE, 1, 0, 2, 0, 0, 0, 0, 32'h80000010, BYP ? 32'hCAFE : 32'h0, 0));

    // Reset state
    id_rs1 = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy_mask", busy_mask, 32'h0);
    check("reset x1_value", x1_value, 32'h0);
    check("reset flags", {sb_overflow, sb_underflow}, 2'b00);
    check("reset rs1_data", rs1_data, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    idle_inputs();

    foreach (tbl[i]) begin
      wb_regwrite = tbl[i].wbw; wb_rd = tbl[i].wbrd; wb_write_data = tbl[i].wdata;
      id_rs1 = tbl[i].rs1; id_rs1_used = tbl[i].u1;
      id_rs2 = tbl[i].rs2; id_rs2_used = tbl[i].u2;
      id_issue = tbl[i].iss; id_issue_we = tbl[i].iwe; id_issue_rd = tbl[i].ird;
      #1;
      check($sformatf("row%0d rs1_data", i), rs1_data, tbl[i].e_rs1);
      check($sformatf("row%0d rs2_data", i), rs2_data, tbl[i].e_rs2);
      check($sformatf("row%0d id_stall", i), id_stall, tbl[i].e_stall);
      $display("row %0d: rs1_data=%h rs2_data=%h id_stall=%b", i, rs1_data, rs2_data, id_stall);
      tick($sformatf("row%0d", i));
    end
    idle_inputs();
    #1;
    check("after table busy_mask[9]", busy_mask[9], 1'b1);
    check("after table busy_mask[11]", busy_mask[11], 1'b0);
    check("after table sb_overflow", sb_overflow, 1'b1);
    check("after table x1_value", x1_value, 32'h80000010);

    // Mid-stream asynchronous reset with cnt[7]=2 and both flags set.
    id_issue = 1'b1; id_issue_we = 1'b1; id_issue_rd = 5'd7;
    tick("pre-reset issue a");
    tick("pre-reset issue b");
    idle_inputs();
    id_rs1 = 5'd7; id_rs1_used = 1'b1; id_rs2 = 5'd9; id_rs2_used = 1'b1;
    #1;
    check("pre-reset id_stall", id_stall, 1'b1);
    check("pre-reset busy_mask[7]", busy_mask[7], 1'b1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async reset busy_mask", busy_mask, 32'h0);
    check("async reset id_stall", id_stall, 1'b0);
    check("async reset rs2_data", rs2_data, 32'h0);
    check("async reset flags", {sb_overflow, sb_underflow}, 2'b00);
    $display("async reset: busy_mask=%h id_stall=%b flags=%b%b",
             busy_mask, id_stall, sb_overflow, sb_underflow);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    idle_inputs();

    // Retire into an idle counter: underflow flag, data still written.
    wb_regwrite = 1'b1; wb_rd = 5'd4; wb_write_data = 32'h0000ABCD;
    tick("underflow");
    idle_inputs();
    id_rs1 = 5'd4;
    #1;
    check("underflow sb_underflow", sb_underflow, 1'b1);
    check("underflow sb_overflow", sb_overflow, 1'b0);
    check("underflow x4 written", rs1_data, 32'h0000ABCD);
    $display("underflow: sb_underflow=%b x4=%h", sb_underflow, rs1_data);

    // Randomised traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      wb_regwrite   = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 7));
      wb_write_data = $urandom;
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_rs1_used   = 1'($urandom_range(0, 1));
      id_rs2_used   = 1'($urandom_range(0, 1));
      id_issue      = 1'($urandom_range(0, 1));
      id_issue_we   = 1'($urandom_range(0, 3) != 0);
      id_issue_rd   = 5'($urandom_range(0, 7));
      check_comb($sformatf("rand%0d", n));
      $display("rand %0d: wb=%b x%0d issue=%b x%0d rs1=%h rs2=%h stall=%b",
               n, wb_regwrite, wb_rd, id_issue && id_issue_we, id_issue_rd,
               rs1_data, rs2_data, id_stall);
      tick($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
